bcd_serial_addsub: RTL and testbench
====================================

BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 Parameter: DIGITS, default 4, number of packed BCD digits per operand (legal range 1..16).
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port: mode  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 Port: a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]; sampled with start.
REQ-007 Port: b  input  4*DIGITS  operand B, same packing as a; sampled with start.
REQ-008 Port: busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-009 Port: done  output  1  single-cycle pulse; result flags are valid in this cycle.
REQ-010 Port: result  output  4*DIGITS  packed BCD sum, or magnitude of difference; held until the next accepted start.
REQ-011 Port: carry_out  output  1  add: decimal overflow out of the top digit; subtract: 1 when A>=B.
REQ-012 Port: negative  output  1  subtract only: 1 when A<B; result then holds |A-B|.
REQ-013 Port: error  output  1  1 when any digit of the latched a or b exceeds 9.

Function
REQ-014 FSM states: IDLE, ADD, COMP, DONE; reset state is IDLE.
REQ-015 IDLE: with start=1, the block latches a, b and mode, clears the digit index to 0 and the flags, and loads the digit carry with mode.
REQ-016 IDLE, start accepted with every digit valid: the next state is ADD.
REQ-017 IDLE, start accepted with any invalid digit: the next state is DONE; error=1, result=0, carry_out=0, negative=0.
REQ-018 ADD: each cycle processes digit i; operand-B digit = b_i (mode 0) or its nine's complement 9-b_i (mode 1).
REQ-019 ADD digit rule: s = a_i + b'_i + carry (5-bit); if s>9, the digit is (s+6)[3:0] and the next carry is 1; otherwise the digit is s[3:0] and the next carry is 0.
REQ-020 ADD: writes the digit into result[4i+3:4i] and increments i; ADD lasts exactly DIGITS cycles.
REQ-021 ADD exit, mode 0: carry_out = final carry, negative=0, next state DONE.
REQ-022 ADD exit, mode 1 with final carry 1: carry_out=1, negative=0, next state DONE; A=B yields result 0, negative=0.
REQ-023 ADD exit, mode 1 with final carry 0: carry_out=0, negative=1, i resets to 0, carry loads 1, next state COMP.
REQ-024 COMP: each cycle replaces result digit i with (9 - r_i + carry) using the REQ-019 correction, producing the ten's complement; COMP lasts exactly DIGITS cycles, then goes to DONE.
REQ-025 DONE: done=1 and busy=0 for exactly one cycle, then IDLE; start in DONE is ignored.
REQ-026 start while busy=1 is ignored; latched operands and mode do not change mid-operation.
REQ-027 Latency from the start-sampling edge to done high: DIGITS+1 cycles (add, or subtract with A>=B); 2*DIGITS+1 cycles (subtract with A<B); 1 cycle (error).
REQ-028 Mode-1 overflow cannot occur; mode-0 overflow wraps the result modulo 10^DIGITS with carry_out=1.

Reset
REQ-029 rst_n=0 forces, immediately and regardless of clk: state IDLE; busy, done, carry_out, negative and error to 0; result and all internal registers to 0.
REQ-030 Reset asserted mid-operation abandons the operation with no done pulse; after release the block accepts a new start on the first edge.

Verification (DIGITS=4)
REQ-031 mode0, a=0x1234, b=0x5678 -> result=0x6912, carry_out=0, negative=0, done 5 cycles after start.
REQ-032 mode0, a=0x9999, b=0x0001 -> result=0x0000, carry_out=1.
REQ-033 mode1, a=0x5000, b=0x1234 -> result=0x3766, carry_out=1, negative=0, done at 5 cycles; a=b=0x4321 -> result=0x0000, negative=0.
REQ-034 mode1, a=0x1234, b=0x5000 -> result=0x3766, negative=1, carry_out=0, done at 9 cycles.
REQ-035 mode0, a=0x12A4 -> error=1, result=0, done at 1 cycle; the next valid operation clears error.
REQ-036 start pulsed with new operands while busy -> ignored and the original result is returned; rst_n low in the 2nd ADD cycle -> all outputs 0, no done; a new start is then processed normally.

Source files
------------

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock,
// with a ten's-complement pass when a subtraction goes negative.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  carry_out,
    output logic                  negative,
    output logic                  error
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, ADD, COMP, DONE} state_t;

    state_t        state_q;
    logic [W-1:0]  a_q, b_q, res_q;
    logic          mode_q, carry_q;
    logic [IW-1:0] idx_q;
    logic          busy_q, done_q, co_q, neg_q, err_q;

    logic          in_bad;
    logic [3:0]    a_dig, b_raw, b_eff, r_dig;
    logic [4:0]    add_d, comp_d;
    logic          last;

    // Returns {carry, digit} with the +6 decimal correction.
    function automatic logic [4:0] bcd_digit(input logic [3:0] x,
                                             input logic [3:0] y,
                                             input logic       c);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y} + {4'b0, c};
        if (s > 5'd9) bcd_digit = {1'b1, s[3:0] + 4'd6};
        else          bcd_digit = {1'b0, s[3:0]};
    endfunction

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) in_bad = 1'b1;
        end
    end

    always_comb begin
        a_dig  = a_q[4*int'(idx_q) +: 4];
        b_raw  = b_q[4*int'(idx_q) +: 4];
        r_dig  = res_q[4*int'(idx_q) +: 4];
        b_eff  = mode_q ? (4'd9 - b_raw) : b_raw;
        add_d  = bcd_digit(a_dig, b_eff, carry_q);
        comp_d = bcd_digit(4'd9 - r_dig, 4'd0, carry_q);
        last   = (idx_q == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            co_q    <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        mode_q  <= mode;
                        idx_q   <= '0;
                        carry_q <= mode;
                        res_q   <= '0;
                        co_q    <= 1'b0;
                        neg_q   <= 1'b0;
                        if (in_bad) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= ADD;
                        end
                    end
                end
                ADD: begin
                    res_q[4*int'(idx_q) +: 4] <= add_d[3:0];
                    carry_q <= add_d[4];
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        // Subtract without end-around carry means A<B.
                        if (!mode_q || add_d[4]) begin
                            co_q    <= add_d[4];
                            neg_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            co_q    <= 1'b0;
                            neg_q   <= 1'b1;
                            idx_q   <= '0;
                            carry_q <= 1'b1;
                            state_q <= COMP;
                        end
                    end
                end
                COMP: begin
                    res_q[4*int'(idx_q) +: 4] <= comp_d[3:0];
                    carry_q <= comp_d[4];
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = res_q;
    assign carry_out = co_q;
    assign negative  = neg_q;
    assign error     = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub (DIGITS=4): add, subtract,
// invalid digits, ignored start while busy, and mid-operation reset.
module tb_bcd_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, carry_out, negative, error;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    bcd_serial_addsub #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .negative(negative), .error(error)
    );

    always #5 clk = ~clk;

    // Issues one start and waits for done; lat counts cycles after the
    // sampling edge (1 = first cycle after it), 0 means timeout.
    task automatic run_op(input logic m, input logic [15:0] av,
                          input logic [15:0] bv, output int lat,
                          output logic b1);
        @(negedge clk);
        start = 1'b1; mode = m; a = av; b = bv;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        b1 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) b1 = busy;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, carry_out, negative, error} !== 5'b0 || result !== 16'h0) begin
            errors++;
            $display("FAIL reset: got busy=%b done=%b co=%b neg=%b err=%b res=%h want all 0",
                     busy, done, carry_out, negative, error, result);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat; logic b1;
        run_op(1'b0, 16'h1234, 16'h5678, lat, b1);
        checks++;
        if (lat !== 5 || result !== 16'h6912 || carry_out !== 1'b0 || negative !== 1'b0) begin
            errors++;
            $display("FAIL add_1234_5678: got lat=%0d res=%h co=%b neg=%b want 5 6912 0 0",
                     lat, result, carry_out, negative);
        end
        checks++;
        if (b1 !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL add_busy: got busy_c1=%b busy_done=%b want 1 0", b1, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b want 0", done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (result !== 16'h6912) begin
            errors++;
            $display("FAIL result_hold: got %h want 6912", result);
        end
        run_op(1'b0, 16'h9999, 16'h0001, lat, b1);
        checks++;
        if (lat !== 5 || result !== 16'h0000 || carry_out !== 1'b1) begin
            errors++;
            $display("FAIL add_overflow: got lat=%0d res=%h co=%b want 5 0000 1",
                     lat, result, carry_out);
        end
        run_op(1'b0, 16'h0595, 16'h0406, lat, b1);
        checks++;
        if (lat !== 5 || result !== 16'h1001 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL add_ripple: got lat=%0d res=%h co=%b want 5 1001 0",
                     lat, result, carry_out);
        end
    endtask

    task automatic test_sub();
        int lat; logic b1;
        run_op(1'b1, 16'h5000, 16'h1234, lat, b1);
        checks++;
        if (lat !== 5 || result !== 16'h3766 || carry_out !== 1'b1 || negative !== 1'b0) begin
            errors++;
            $display("FAIL sub_pos: got lat=%0d res=%h co=%b neg=%b want 5 3766 1 0",
                     lat, result, carry_out, negative);
        end
        run_op(1'b1, 16'h4321, 16'h4321, lat, b1);
        checks++;
        if (lat !== 5 || result !== 16'h0000 || carry_out !== 1'b1 || negative !== 1'b0) begin
            errors++;
            $display("FAIL sub_equal: got lat=%0d res=%h co=%b neg=%b want 5 0000 1 0",
                     lat, result, carry_out, negative);
        end
        run_op(1'b1, 16'h1234, 16'h5000, lat, b1);
        checks++;
        if (lat !== 9 || result !== 16'h3766 || carry_out !== 1'b0 || negative !== 1'b1) begin
            errors++;
            $display("FAIL sub_neg: got lat=%0d res=%h co=%b neg=%b want 9 3766 0 1",
                     lat, result, carry_out, negative);
        end
        run_op(1'b1, 16'h0000, 16'h0001, lat, b1);
        checks++;
        if (lat !== 9 || result !== 16'h0001 || negative !== 1'b1) begin
            errors++;
            $display("FAIL sub_neg_small: got lat=%0d res=%h neg=%b want 9 0001 1",
                     lat, result, negative);
        end
    endtask

    task automatic test_error();
        int lat; logic b1;
        run_op(1'b0, 16'h12A4, 16'h0001, lat, b1);
        checks++;
        if (lat !== 1 || error !== 1'b1 || result !== 16'h0 || carry_out !== 1'b0 ||
            negative !== 1'b0 || b1 !== 1'b0) begin
            errors++;
            $display("FAIL err_a: got lat=%0d err=%b res=%h co=%b neg=%b busy=%b want 1 1 0 0 0 0",
                     lat, error, result, carry_out, negative, b1);
        end
        run_op(1'b1, 16'h0001, 16'hF000, lat, b1);
        checks++;
        if (lat !== 1 || error !== 1'b1) begin
            errors++;
            $display("FAIL err_b: got lat=%0d err=%b want 1 1", lat, error);
        end
        run_op(1'b0, 16'h0002, 16'h0003, lat, b1);
        checks++;
        if (lat !== 5 || error !== 1'b0 || result !== 16'h0005) begin
            errors++;
            $display("FAIL err_clear: got lat=%0d err=%b res=%h want 5 0 0005",
                     lat, error, result);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 16'h1234; b = 16'h5678;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 2) begin
                start = 1'b1; mode = 1'b1; a = 16'h0001; b = 16'h0009;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat !== 5 || result !== 16'h6912 || negative !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore: got lat=%0d res=%h neg=%b want 5 6912 0",
                     lat, result, negative);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic b1; logic saw_done;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 16'h1111; b = 16'h2222;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, carry_out, negative, error} !== 5'b0 || result !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b co=%b neg=%b err=%b res=%h want all 0",
                     busy, done, carry_out, negative, error, result);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got done seen=%b want 0", saw_done);
        end
        run_op(1'b0, 16'h0808, 16'h0303, lat, b1);
        checks++;
        if (lat !== 5 || result !== 16'h1111 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got lat=%0d res=%h co=%b want 5 1111 0",
                     lat, result, carry_out);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_error();
        test_busy_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
